ks_pipe_subtractor: RTL and testbench
=====================================

// Module: ks_pipe_subtractor
// PURPOSE
//   Pipelined Kogge-Stone subtractor with valid/ready streaming handshake. It is the inverse-operation companion of the
//   team's Kogge-Stone adder. It computes DIFF = A - B as A + ~B + 1 using the same square/black-cell/triangle prefix
//   structure. The prefix tree is split across two register stages so the result can drive a registered TinyTapeout
//   output. It also serves as the reference subtractor for adder cross-checks.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; power of two, 4..32
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      reset, asynchronous, active-low
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      subtractor can accept an operand pair this cycle
//   a          in   WIDTH  minuend, unsigned
//   b          in   WIDTH  subtrahend, unsigned
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   diff       out  WIDTH  A - B (mod 2^WIDTH, or saturated, see CONFIGURATION)
//   borrow     out  1      1 when A < B (= NOT carry-out of A + ~B + 1)
//   zero       out  1      1 when the unsaturated difference == 0 (A == B)
// BEHAVIOUR
//   - Reset: s1_valid, s2_valid, out_valid, diff, borrow, zero all 0. in_ready forced 0 while rst_n low; 1 in the first cycle after release.
//   - Stage 1 (capture, on in_valid & in_ready):
//       nb = ~b; g = a & nb; p = a ^ nb
//       g[0] folded with cin=1: g[0] = a[0] | nb[0]
//       registers g, p, s1_valid
//   - Stage 2 (prefix, on s1 advance):
//       log2(WIDTH) Kogge-Stone levels combinationally; level k black cell at i >= 2^k:
//         G = Gi | (Pi & G[i-2^k]);  P = Pi & P[i-2^k]
//       positions below 2^k pass through
//       registers prefix G, the original p, s2_valid
//   - Output, combinational from stage 2 regs:
//       diff[0] = p[0] ^ 1; diff[i] = p[i] ^ G[i-1]
//       borrow = ~G[WIDTH-1]; zero = (unsaturated diff == 0)
//   - out_valid = s2_valid. Latency: 2 cycles from accepting edge to out_valid.
//   - Flow control:
//       s2 advances when !s2_valid | out_ready; s1 advances when !s1_valid | s2 advance
//       in_ready = s1 advance
//       full throughput: 1 op/cycle with out_ready held 1
//   - Stall: out_valid & !out_ready holds diff/borrow/zero stable and s2 frozen. At most 2 ops buffered. No drop, no
//     duplication, strict FIFO order.
//   - Simultaneous: stage 2 consume and new capture in the same cycle are legal; each stage reloads in place.
//   - Reset mid-operation: in-flight ops discarded; out_valid drops asynchronously.
//   - Wrap-around (no macro): 0x00 - 0x01 = 0xFF, borrow=1.
// CONFIGURATION
//   KS_SUB_SATURATE_EN  defined: when borrow=1, diff forced to 0 (unsigned floor); borrow and zero still report the raw
//                       result, so zero=0 for a saturated result.
//                       undefined: diff is modulo 2^WIDTH; no extra logic.
// STRUCTURE
//   - Package ks_pkg:
//       KS_LEVELS(w) = $clog2(w) function
//       typedef struct {logic g; logic p;} ks_gp_t
//       localparam KS_CIN_SUB = 1'b1
//   - Sub-module ks_black_cell: (gi, pi, gprev, pprev) -> (g, p); generate-instantiated per level and position.
//   - Top: stage registers, handshake logic, sum/triangle XOR and saturation mux.
// TESTING (WIDTH=8)
//   1. 0x05 - 0x03 -> diff=0x02, borrow=0, zero=0, out_valid exactly 2 cycles after accept.
//   2. 0x03 - 0x05 -> diff=0xFE, borrow=1; with KS_SUB_SATURATE_EN: diff=0x00, borrow=1, zero=0.
//   3. 0x00 - 0x01 -> diff=0xFF, borrow=1 (full-length borrow chain); 0x80 - 0x80 -> diff=0x00, zero=1, borrow=0.
//   4. Stream 0x10-0x01, 0x20-0x02, 0x30-0x03 back-to-back with out_ready=0 for 4 cycles:
//        in_ready low after 2 accepts, outputs stable while stalled
//        then 0x0F, 0x1E, 0x2D delivered in order, one per cycle
//   5. Throughput: 256 random pairs with out_ready=1 -> one result/cycle, all match a - b mod 256.
//   6. Assert rst_n low with 2 ops in flight -> out_valid=0 immediately, no stale result after release; next op 0x09 - 0x04 -> 0x05.

Source files
------------

// File: rtl/ks_pipe_subtractor_pkg.sv
// Shared types and constants for the Kogge-Stone subtractor slice.
package ks_pkg;

  // A - B is computed as A + ~B + 1, so the carry-in is fixed high.
  localparam logic KS_CIN_SUB = 1'b1;

  typedef struct packed {
    logic g;
    logic p;
  } ks_gp_t;

  function automatic int unsigned KS_LEVELS(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/ks_black_cell.sv
// Kogge-Stone black cell: merges a generate/propagate pair with its predecessor span.
module ks_black_cell (
  input  logic gi,
  input  logic pi,
  input  logic gprev,
  input  logic pprev,
  output logic g,
  output logic p
);

  assign g = gi | (pi & gprev);
  assign p = pi & pprev;

endmodule

// File: rtl/ks_pipe_subtractor.sv
// Two-stage pipelined Kogge-Stone subtractor (A - B) with valid/ready streaming.
// Optional macro KS_SUB_SATURATE_EN clamps the difference to 0 when A < B.
import ks_pkg::*;

module ks_pipe_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int unsigned LEVELS = KS_LEVELS(WIDTH);

  ks_gp_t [WIDTH-1:0] s1_gp_d, s1_gp_q;
  ks_gp_t [WIDTH-1:0] s2_gp_d, s2_gp_q;
  logic               s1_valid_q, s2_valid_q;
  logic               s1_adv, s2_adv;

  logic [WIDTH-1:0]   nb;
  logic [WIDTH-1:0]   s1_g, s1_p;
  logic [WIDTH-1:0]   s2_g, s2_p;
  logic [WIDTH-1:0]   prefix_g;
  logic [WIDTH-1:0]   prefix_p_unused;
  logic [WIDTH-1:0]   raw_diff, diff_sel;
  logic               raw_borrow, raw_zero;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = rst_n & s1_adv;
  assign out_valid = s2_valid_q;

  // Bit 0 absorbs the constant carry-in into its generate term.
  always_comb begin
    nb = ~b;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s1_gp_d[i].g = a[i] & nb[i];
      s1_gp_d[i].p = a[i] ^ nb[i];
    end
    s1_gp_d[0].g = (a[0] & nb[0]) | ((a[0] ^ nb[0]) & KS_CIN_SUB);
  end

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s1_g[i] = s1_gp_q[i].g;
      s1_p[i] = s1_gp_q[i].p;
    end
  end

  // Each level lives in its own block so level k+1 never reads the vector it drives.
  for (genvar k = 0; k < int'(LEVELS); k++) begin : g_lvl
    logic [WIDTH-1:0] gin, pin, gout, pout;

    if (k == 0) begin : g_src_s1
      assign gin = s1_g;
      assign pin = s1_p;
    end else begin : g_src_prev
      assign gin = g_lvl[k-1].gout;
      assign pin = g_lvl[k-1].pout;
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pos
      if (i >= (1 << k)) begin : g_cell
        ks_black_cell u_cell (
          .gi    (gin[i]),
          .pi    (pin[i]),
          .gprev (gin[i-(1<<k)]),
          .pprev (pin[i-(1<<k)]),
          .g     (gout[i]),
          .p     (pout[i])
        );
      end else begin : g_pass
        assign gout[i] = gin[i];
        assign pout[i] = pin[i];
      end
    end
  end

  assign prefix_g        = g_lvl[LEVELS-1].gout;
  assign prefix_p_unused = g_lvl[LEVELS-1].pout;

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s2_gp_d[i].g = prefix_g[i];
      s2_gp_d[i].p = s1_p[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_gp_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_gp_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_gp_q <= s1_gp_d;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_gp_q <= s2_gp_d;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s2_g[i] = s2_gp_q[i].g;
      s2_p[i] = s2_gp_q[i].p;
    end
    raw_diff    = '0;
    raw_diff[0] = s2_p[0] ^ KS_CIN_SUB;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      raw_diff[i] = s2_p[i] ^ s2_g[i-1];
    end
    raw_borrow = ~s2_g[WIDTH-1];
    raw_zero   = (raw_diff == '0);
  end

`ifdef KS_SUB_SATURATE_EN
  assign diff_sel = raw_borrow ? '0 : raw_diff;
`else
  assign diff_sel = raw_diff;
`endif

  // Outputs read as zero whenever stage 2 holds no result, including during reset.
  assign diff   = s2_valid_q ? diff_sel : '0;
  assign borrow = s2_valid_q & raw_borrow;
  assign zero   = s2_valid_q & raw_zero;

endmodule

// File: tb/tb_ks_pipe_subtractor.sv
// Self-checking bench for ks_pipe_subtractor (WIDTH=8) against an arithmetic reference model.
module tb_ks_pipe_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;

  int checks = 0;
  int failures = 0;

  ks_pipe_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {zero, borrow, diff} from plain integer subtraction.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    int           d;
    logic [W-1:0] r;
    logic         br, zr;
    d  = int'(x) - int'(y);
    br = (d < 0);
    zr = (d == 0);
    r  = d[W-1:0];
`ifdef KS_SUB_SATURATE_EN
    if (br) r = '0;
`endif
    return {zr, br, r};
  endfunction

  task automatic expect_out(input string tag, input logic [W+1:0] e);
    check_eq({tag, ".valid"}, out_valid, 1);
    check_eq({tag, ".diff"}, diff, e[W-1:0]);
    check_eq({tag, ".borrow"}, borrow, e[W]);
    check_eq({tag, ".zero"}, zero, e[W+1]);
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); check_eq({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check_eq({tag, ".lat1"}, out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk); expect_out(tag, ref_sub(x, y));
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input string tag, input int n, input int vpct, input int rpct,
                            input bit strict_tp);
    logic [W+1:0] expq[$];
    logic [W+1:0] e;
    logic [W+2:0] held;
    bit           hold_prev;
    int           sent, got, cycles, gaps;
    sent = 0; got = 0; cycles = 0; gaps = 0; hold_prev = 1'b0; held = '0;
    while (got < n && cycles < n * 20 + 100) begin
      in_valid  = (sent < n) && (($urandom % 100) < vpct);
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = (($urandom % 100) < rpct);
      @(negedge clk);
      cycles++;
      if (hold_prev) check_eq({tag, ".hold"}, {out_valid, zero, borrow, diff}, held);
      if (strict_tp && got > 0 && got < n && !out_valid) gaps++;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check_eq({tag, ".spurious"}, out_valid, 0);
        else begin
          e = expq.pop_front();
          check_eq({tag, ".diff"}, diff, e[W-1:0]);
          check_eq({tag, ".borrow"}, borrow, e[W]);
          check_eq({tag, ".zero"}, zero, e[W+1]);
        end
        got++;
      end
      hold_prev = out_valid && !out_ready;
      held      = {out_valid, zero, borrow, diff};
      if (in_valid && in_ready) begin
        expq.push_back(ref_sub(a, b));
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq({tag, ".count"}, got, n);
    if (strict_tp) check_eq({tag, ".gaps"}, gaps, 0);
  endtask

  initial begin
    // Reset state
    #3;
    check_eq("rst.in_ready", in_ready, 0);
    check_eq("rst.out_valid", out_valid, 0);
    check_eq("rst.diff", diff, 0);
    check_eq("rst.borrow", borrow, 0);
    check_eq("rst.zero", zero, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst.release_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed corner cases
    do_op("t1", 8'h05, 8'h03);
    do_op("t2", 8'h03, 8'h05);
    do_op("t3a", 8'h00, 8'h01);
    do_op("t3b", 8'h80, 8'h80);
    do_op("t3c", 8'hFF, 8'h00);

    // Back-pressure: two accepts fill the pipe, third waits
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h10; b = 8'h01;
    @(negedge clk); check_eq("t4.rdy1", in_ready, 1);
    @(posedge clk); #1 a = 8'h20; b = 8'h02;
    @(negedge clk); check_eq("t4.rdy2", in_ready, 1);
    @(posedge clk); #1 a = 8'h30; b = 8'h03;
    @(negedge clk); check_eq("t4.rdy3", in_ready, 0);
    expect_out("t4.stall1", ref_sub(8'h10, 8'h01));
    @(posedge clk); #1;
    @(negedge clk); check_eq("t4.rdy4", in_ready, 0);
    expect_out("t4.stall2", ref_sub(8'h10, 8'h01));
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); check_eq("t4.rdy5", in_ready, 1);
    expect_out("t4.o1", ref_sub(8'h10, 8'h01));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); expect_out("t4.o2", ref_sub(8'h20, 8'h02));
    @(posedge clk); #1;
    @(negedge clk); expect_out("t4.o3", ref_sub(8'h30, 8'h03));
    @(posedge clk); #1;
    @(negedge clk); check_eq("t4.drained", out_valid, 0);
    @(posedge clk); #1;

    // Full throughput, then random handshakes
    run_stream("t5", 256, 100, 100, 1'b1);
    run_stream("rnd", 300, 70, 60, 1'b0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset with two ops in flight
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h44; b = 8'h11;
    @(posedge clk); #1 a = 8'h55; b = 8'h22;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check_eq("t6.pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6.async_valid", out_valid, 0);
    check_eq("t6.async_ready", in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); check_eq("t6.no_stale", out_valid, 0);
      @(posedge clk); #1;
    end
    do_op("t6", 8'h09, 8'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
